// File: rtl/irrevocable_arb_pkg.sv
// Shared types and helpers for the irrevocable round-robin arbiter.
package irrevocable_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int next_rr_index(input int idx, input int num_req);
        return (idx >= num_req - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester after i_last_grant, wrapping modulo NUM_REQ.
module rr_priority_pick
    import irrevocable_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_last_grant,
    output logic                o_found,
    output logic [ID_WIDTH-1:0] o_grant
);

    always_comb begin
        int idx;
        o_found = 1'b0;
        o_grant = '0;
        idx     = int'(i_last_grant);
        // Scan last+1, last+2, ... so the previous winner is considered last.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = next_rr_index(idx, NUM_REQ);
            if (!o_found && (|(i_req & (NUM_REQ'(1) << idx)))) begin
                o_found = 1'b1;
                o_grant = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/irrevocable_rr_arbiter.sv
// Round-robin arbiter with packet lock feeding one irrevocable valid/ready channel
// through a single registered output stage.
module irrevocable_rr_arbiter
    import irrevocable_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          io_clock,
    input  logic                          io_reset_n,
    input  logic [NUM_REQ-1:0]            io_in_valid,
    output logic [NUM_REQ-1:0]            io_in_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] io_in_bits,
    input  logic [NUM_REQ-1:0]            io_in_last,
    output logic                          io_out_valid,
    input  logic                          io_out_ready,
    output logic [DATA_WIDTH-1:0]         io_out_bits,
    output logic                          io_out_last,
    output logic [ID_WIDTH-1:0]           io_out_id,
    output logic                          io_busy
);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [ID_WIDTH-1:0]     r_grant;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_bits;
    logic                    r_out_last;
    logic [ID_WIDTH-1:0]     r_out_id;

    logic                    w_found;
    logic [ID_WIDTH-1:0]     w_pick;
    logic                    w_do_grant;
    logic [NUM_REQ-1:0]      w_grant_oh;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_bits;
    logic                    w_out_space;
    logic                    w_in_fire;

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .i_req        (io_in_valid),
        .i_last_grant (r_grant),
        .o_found      (w_found),
        .o_grant      (w_pick)
    );

    // r_grant doubles as the owner of the channel while LOCKED.
    assign w_grant_oh  = NUM_REQ'(1) << r_grant;
    assign w_sel_valid = |(io_in_valid & w_grant_oh);
    assign w_sel_last  = |(io_in_last & w_grant_oh);
    assign w_out_space = !r_out_valid || io_out_ready;

    always_comb begin
        w_sel_bits = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_bits = io_in_bits[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        io_in_ready = '0;
        w_in_fire   = 1'b0;
        w_do_grant  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                io_in_ready = w_out_space ? w_grant_oh : '0;
                w_in_fire   = w_sel_valid && w_out_space;
                if (w_in_fire && w_sel_last) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge io_clock) begin
        if (!io_reset_n) begin
            r_state     <= ARB_IDLE;
            r_grant     <= ID_WIDTH'(NUM_REQ - 1);
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_last  <= 1'b0;
            r_out_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_do_grant) begin
                r_grant <= w_pick;
            end
            // A new beat may replace the one leaving in the same cycle.
            if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_bits  <= w_sel_bits;
                r_out_last  <= w_sel_last;
                r_out_id    <= r_grant;
            end else if (io_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_out_valid = r_out_valid;
    assign io_out_bits  = r_out_bits;
    assign io_out_last  = r_out_last;
    assign io_out_id    = r_out_id;
    assign io_busy      = (r_state == ARB_LOCKED) || r_out_valid;

endmodule

// File: tb/tb_irrevocable_rr_arbiter.sv
// Directed bench for irrevocable_rr_arbiter with per-requester beat queues and an output scoreboard.
module tb_irrevocable_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] bits;
        logic          last;
    } beat_t;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] bits;
        logic          last;
    } exp_t;

    logic             io_clock = 1'b0;
    logic             io_reset_n;
    logic [NR-1:0]    io_in_valid;
    logic [NR-1:0]    io_in_ready;
    logic [NR*DW-1:0] io_in_bits;
    logic [NR-1:0]    io_in_last;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [DW-1:0]    io_out_bits;
    logic             io_out_last;
    logic [1:0]       io_out_id;
    logic             io_busy;

    beat_t rq [NR][$];
    exp_t  sb [$];
    int    fire_cyc [$];
    int    cyc_n  = 0;
    int    n_vec  = 0;
    int    n_fail = 0;
    bit    manual = 1'b1;

    irrevocable_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .io_clock     (io_clock),
        .io_reset_n   (io_reset_n),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_in_last   (io_in_last),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_last  (io_out_last),
        .io_out_id    (io_out_id),
        .io_busy      (io_busy)
    );

    always #5 io_clock = ~io_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int r, input logic [DW-1:0] b, input logic l);
        beat_t x;
        x.bits = b;
        x.last = l;
        rq[r].push_back(x);
    endtask

    task automatic expect_out(input logic [1:0] id, input logic [DW-1:0] b, input logic l);
        exp_t e;
        e.id   = id;
        e.bits = b;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic drive_inputs();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] b;
        v = '0;
        l = '0;
        b = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                v[i]          = 1'b1;
                l[i]          = rq[i][0].last;
                b[i*DW +: DW] = rq[i][0].bits;
            end
        end
        io_in_valid = v;
        io_in_last  = l;
        io_in_bits  = b;
    endtask

    // One clock: score the output handshake, advance requester queues, re-drive at negedge.
    task automatic cyc();
        logic [NR-1:0] f;
        exp_t          e;
        #1;
        f = io_in_valid & io_in_ready;
        if (io_out_valid === 1'b1 && io_out_ready === 1'b1) begin
            fire_cyc.push_back(cyc_n);
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("out_id", io_out_id, e.id);
                chk("out_bits", io_out_bits, e.bits);
                chk("out_last", io_out_last, e.last);
            end
        end
        @(posedge io_clock);
        cyc_n++;
        for (int i = 0; i < NR; i++) begin
            if (f[i] === 1'b1) void'(rq[i].pop_front());
        end
        @(negedge io_clock);
        if (!manual) drive_inputs();
    endtask

    task automatic drain(input string tag, input int maxc);
        for (int k = 0; k < maxc; k++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        io_reset_n   = 1'b0;
        io_out_ready = 1'b0;
        io_in_valid  = '1;
        io_in_bits   = '0;
        io_in_last   = '0;

        // Reset held with every requester valid
        repeat (5) begin
            cyc();
            chk("rst_out_valid", io_out_valid, 0);
            chk("rst_in_ready", io_in_ready, 0);
            chk("rst_busy", io_busy, 0);
        end
        chk("rst_out_bits", io_out_bits, 0);
        chk("rst_out_id", io_out_id, 0);
        manual = 1'b0;
        drive_inputs();
        io_reset_n   = 1'b1;
        io_out_ready = 1'b1;
        cyc();
        chk("idle_busy", io_busy, 0);

        // Single requester, 3-beat packet, latency and last marking
        beat(1, 8'h11, 0); beat(1, 8'h12, 0); beat(1, 8'h13, 1);
        expect_out(1, 8'h11, 0); expect_out(1, 8'h12, 0); expect_out(1, 8'h13, 1);
        drive_inputs();
        cyc();
        chk("t2_ready_grant", io_in_ready, 4'b0010);
        chk("t2_no_out_yet", io_out_valid, 0);
        cyc();
        chk("t2_first_valid", io_out_valid, 1);
        chk("t2_first_bits", io_out_bits, 8'h11);
        chk("t2_first_last", io_out_last, 0);
        cyc();
        chk("t2_second_bits", io_out_bits, 8'h12);
        cyc();
        chk("t2_third_bits", io_out_bits, 8'h13);
        chk("t2_third_last", io_out_last, 1);
        drain("t2_drain", 10);
        chk("t2_busy_after", io_busy, 0);

        // Reset pulse restores requester 0 as top priority
        io_reset_n = 1'b0;
        cyc();
        chk("rst2_out_valid", io_out_valid, 0);
        io_reset_n = 1'b1;

        // All four valid with single-beat packets: 0,1,2,3,0 with a gap cycle each
        beat(0, 8'hA0, 1); beat(0, 8'hA4, 1);
        beat(1, 8'hA1, 1); beat(2, 8'hA2, 1); beat(3, 8'hA3, 1);
        expect_out(0, 8'hA0, 1); expect_out(1, 8'hA1, 1); expect_out(2, 8'hA2, 1);
        expect_out(3, 8'hA3, 1); expect_out(0, 8'hA4, 1);
        fire_cyc.delete();
        drive_inputs();
        drain("t3_drain", 40);
        chk("t3_fires", fire_cyc.size(), 5);
        for (int k = 1; k < fire_cyc.size(); k++) begin
            chk("t3_gap", fire_cyc[k] - fire_cyc[k-1], 2);
        end

        // Stall mid-packet on requester 2 while requester 1 waits
        beat(2, 8'hB0, 0); beat(2, 8'hB1, 0); beat(2, 8'hB2, 1);
        expect_out(2, 8'hB0, 0); expect_out(2, 8'hB1, 0); expect_out(2, 8'hB2, 1);
        drive_inputs();
        cyc();
        cyc();
        io_out_ready = 1'b0;
        beat(1, 8'hC0, 1);
        expect_out(1, 8'hC0, 1);
        drive_inputs();
        repeat (6) begin
            cyc();
            chk("t4_hold_valid", io_out_valid, 1);
            chk("t4_hold_bits", io_out_bits, 8'hB0);
            chk("t4_hold_id", io_out_id, 2);
            chk("t4_no_ready", io_in_ready, 0);
        end
        io_out_ready = 1'b1;
        drain("t4_drain", 20);

        // Packet lock: requester 3 waits for requester 0's whole packet
        beat(0, 8'hD0, 0); beat(0, 8'hD1, 0); beat(0, 8'hD2, 0); beat(0, 8'hD3, 1);
        expect_out(0, 8'hD0, 0); expect_out(0, 8'hD1, 0);
        expect_out(0, 8'hD2, 0); expect_out(0, 8'hD3, 1);
        drive_inputs();
        cyc();
        beat(3, 8'hE0, 1);
        expect_out(3, 8'hE0, 1);
        drive_inputs();
        for (int k = 0; k < 30; k++) begin
            if (sb.size() == 0) break;
            if (rq[0].size() > 0) chk("t5_lock_ready3", io_in_ready[3], 0);
            cyc();
        end
        chk("t5_drain", sb.size(), 0);

        // Reset while locked with a buffered beat
        beat(1, 8'hF0, 0); beat(1, 8'hF1, 0); beat(1, 8'hF2, 1);
        drive_inputs();
        cyc();
        cyc();
        chk("t6_pre_valid", io_out_valid, 1);
        io_out_ready = 1'b0;
        io_reset_n   = 1'b0;
        cyc();
        chk("t6_rst_valid", io_out_valid, 0);
        chk("t6_rst_busy", io_busy, 0);
        chk("t6_rst_ready", io_in_ready, 0);
        rq[1].delete();
        beat(3, 8'h30, 1);
        beat(1, 8'h10, 1);
        expect_out(1, 8'h10, 1);
        expect_out(3, 8'h30, 1);
        drive_inputs();
        cyc();
        chk("t6_rst_hold_ready", io_in_ready, 0);
        io_reset_n   = 1'b1;
        io_out_ready = 1'b1;
        cyc();
        chk("t6_first_grant", io_in_ready, 4'b0010);
        drain("t6_drain", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
